// File: rtl/scan_fg_pe_array_if.sv
// Beat interface between the alpha LLR store read side and the SCAN PE array.
// The master drives the read beat; the slave returns the write-back beat.
interface scan_fg_pe_array_if #(
    parameter int Q = 6,
    parameter int P = 256
);
    logic           in_valid;
    logic           op;
    logic [4:0]     layer_in;
    logic [4:0]     cnt_in;
    logic [P*Q-1:0] a_left;
    logic [P*Q-1:0] a_right;
    logic [P*Q-1:0] beta;
    logic [P*Q-1:0] a_out;
    logic           w_en;
    logic [4:0]     layer_w;
    logic [4:0]     cnta;
    logic           err_layer;

    modport master (
        output in_valid, op, layer_in, cnt_in, a_left, a_right, beta,
        input  a_out, w_en, layer_w, cnta, err_layer
    );

    modport slave (
        input  in_valid, op, layer_in, cnt_in, a_left, a_right, beta,
        output a_out, w_en, layer_w, cnta, err_layer
    );
endinterface

// File: rtl/scan_fg_pe_array.sv
// P-lane SCAN f/g min-sum PE array: beat captured at edge n, write-back beat
// (or illegal-layer pulse) visible for one cycle after edge n+2.
module scan_fg_pe_array #(
    parameter int Q = 6,
    parameter int P = 256,
    parameter int N = 1024
) (
    input logic               clk,
    input logic               rst,
    scan_fg_pe_array_if.slave pe
);
    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned LOGP = $clog2(P);

    localparam logic signed [Q-1:0] SMAX = {1'b0, {(Q-1){1'b1}}};
    localparam logic signed [Q-1:0] SMIN = {1'b1, {(Q-1){1'b0}}};
    localparam logic signed [Q-1:0] SNEG = {1'b1, {(Q-2){1'b0}}, 1'b1};
    localparam logic signed [Q:0]   WMAX = {2'b00, {(Q-1){1'b1}}};
    localparam logic signed [Q:0]   WMIN = {2'b11, {(Q-2){1'b0}}, 1'b1};

    function automatic logic signed [Q-1:0] f_fix(input logic signed [Q-1:0] x);
        return (x == SMIN) ? SNEG : x;
    endfunction

    function automatic logic signed [Q-1:0] f_sat(input logic signed [Q:0] x);
        if (x > WMAX) return SMAX;
        if (x < WMIN) return SNEG;
        return x[Q-1:0];
    endfunction

    function automatic logic [Q-2:0] f_mag(input logic signed [Q-1:0] x);
        logic signed [Q-1:0] n;
        n = -x;
        return x[Q-1] ? n[Q-2:0] : x[Q-2:0];
    endfunction

    // Input capture register: the raw beat and its tags.
    logic           r0_valid, r0_op;
    logic [4:0]     r0_layer, r0_cnt;
    logic [P*Q-1:0] r0_a, r0_b, r0_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid <= 1'b0;
            r0_op    <= 1'b0;
            r0_layer <= '0;
            r0_cnt   <= '0;
            r0_a     <= '0;
            r0_b     <= '0;
            r0_e     <= '0;
        end else begin
            r0_valid <= pe.in_valid;
            r0_op    <= pe.op;
            r0_layer <= pe.layer_in;
            r0_cnt   <= pe.cnt_in;
            r0_a     <= pe.a_left;
            r0_b     <= pe.a_right;
            r0_e     <= pe.beta;
        end
    end

    // Stage 1: partner operand (sat(B+E) for f, E for g), signs and min magnitude.
    logic [P-1:0]       w1_sa, w1_sx;
    logic [P*(Q-1)-1:0] w1_min;
    logic [P*Q-1:0]     w1_b;

    always_comb begin : p_stage1
        logic signed [Q-1:0] v_a, v_b, v_e, v_x;
        logic [Q-2:0]        v_ma, v_mx;
        v_a = '0; v_b = '0; v_e = '0; v_x = '0; v_ma = '0; v_mx = '0;
        w1_sa  = '0;
        w1_sx  = '0;
        w1_min = '0;
        w1_b   = '0;
        for (int unsigned i = 0; i < P; i++) begin
            v_a  = f_fix(r0_a[i*Q +: Q]);
            v_b  = f_fix(r0_b[i*Q +: Q]);
            v_e  = f_fix(r0_e[i*Q +: Q]);
            v_x  = r0_op ? v_e : f_sat({v_b[Q-1], v_b} + {v_e[Q-1], v_e});
            v_ma = f_mag(v_a);
            v_mx = f_mag(v_x);
            w1_sa[i] = v_a[Q-1];
            w1_sx[i] = v_x[Q-1];
            w1_min[i*(Q-1) +: (Q-1)] = (v_ma < v_mx) ? v_ma : v_mx;
            w1_b[i*Q +: Q] = v_b;
        end
    end

    logic               r1_valid, r1_op;
    logic [4:0]         r1_layer, r1_cnt;
    logic [P-1:0]       r1_sa, r1_sx;
    logic [P*(Q-1)-1:0] r1_min;
    logic [P*Q-1:0]     r1_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_op    <= 1'b0;
            r1_layer <= '0;
            r1_cnt   <= '0;
            r1_sa    <= '0;
            r1_sx    <= '0;
            r1_min   <= '0;
            r1_b     <= '0;
        end else begin
            r1_valid <= r0_valid;
            r1_op    <= r0_op;
            r1_layer <= r0_layer;
            r1_cnt   <= r0_cnt;
            r1_sa    <= w1_sa;
            r1_sx    <= w1_sx;
            r1_min   <= w1_min;
            r1_b     <= w1_b;
        end
    end

    // Stage 2: apply sign, g addition with saturation, lane mask by layer width.
    logic           w2_legal;
    logic [P*Q-1:0] w2_a;

    always_comb begin : p_stage2
        logic signed [Q-1:0] v_m, v_b;
        logic                v_act;
        int unsigned         v_lw;
        v_m = '0; v_b = '0; v_act = 1'b0;
        v_lw     = 32'(r1_layer);
        w2_legal = (v_lw >= 32'd1) && (v_lw <= LOGN);
        w2_a     = '0;
        for (int unsigned i = 0; i < P; i++) begin
            v_m = {1'b0, r1_min[i*(Q-1) +: (Q-1)]};
            if (r1_sa[i] ^ r1_sx[i]) v_m = -v_m;
            v_b   = r1_b[i*Q +: Q];
            // A layer-L beat carries 2^(L-1) pairs; wider layers fill every lane.
            v_act = (v_lw > LOGP) || ((v_lw != 0) && (i < (32'd1 << (v_lw - 32'd1))));
            if (r1_valid && w2_legal && v_act)
                w2_a[i*Q +: Q] = r1_op ? f_sat({v_b[Q-1], v_b} + {v_m[Q-1], v_m}) : v_m;
        end
    end

    logic           r_w_en, r_err;
    logic [4:0]     r_layer_w, r_cnta;
    logic [P*Q-1:0] r_a_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_en    <= 1'b0;
            r_err     <= 1'b0;
            r_layer_w <= '0;
            r_cnta    <= '0;
            r_a_out   <= '0;
        end else begin
            r_w_en    <= r1_valid && w2_legal;
            r_err     <= r1_valid && !w2_legal;
            r_layer_w <= (r1_valid && w2_legal) ? r1_layer - 5'd1 : '0;
            r_cnta    <= (r1_valid && w2_legal) ? r1_cnt : '0;
            r_a_out   <= w2_a;
        end
    end

    assign pe.w_en      = r_w_en;
    assign pe.err_layer = r_err;
    assign pe.layer_w   = r_layer_w;
    assign pe.cnta      = r_cnta;
    assign pe.a_out     = r_a_out;
endmodule

// File: tb/tb_scan_fg_pe_array.sv
// Bench for scan_fg_pe_array: directed vector table plus a cycle-driven
// sequence checked against a per-lane arithmetic reference model.
module tb_scan_fg_pe_array;
    localparam int Q  = 6;
    localparam int P  = 256;
    localparam int N  = 1024;
    localparam int MX = 2**(Q-1) - 1;
    localparam int HMAX = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_fg_pe_array_if #(.Q(Q), .P(P)) bus ();
    scan_fg_pe_array #(.Q(Q), .P(P), .N(N)) dut (.clk(clk), .rst(rst), .pe(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic           rst, valid, op;
        logic [4:0]     layer, cnt;
        logic [P*Q-1:0] a, b, e;
    } stim_t;

    typedef struct {
        logic           wen, err;
        logic [4:0]     lw, cn;
        logic [P*Q-1:0] a;
    } exp_t;

    typedef struct {
        bit op;
        int layer;
        int cnt;
        int a[4];
        int b[4];
        int e[4];
        int fill;
        int ex[4];
        int ex_hi;
        bit wen;
        bit err;
        int lw;
    } vec_t;

    stim_t hist [HMAX];
    int    cyc = 0;
    string phase = "reset";

    function automatic int fixv(int x); return (x < -MX) ? -MX : x; endfunction
    function automatic int satv(int x); return (x > MX) ? MX : ((x < -MX) ? -MX : x); endfunction
    function automatic int sgnv(int x); return (x >= 0) ? 1 : -1; endfunction
    function automatic int absv(int x); return (x < 0) ? -x : x; endfunction
    function automatic int minv(int x, int y); return (x < y) ? x : y; endfunction

    function automatic int lane_ref(bit op, int a_in, int b_in, int e_in);
        int a, b, e, t, m;
        a = fixv(a_in); b = fixv(b_in); e = fixv(e_in);
        if (!op) begin
            t = satv(b + e);
            return sgnv(a) * sgnv(t) * minv(absv(a), absv(t));
        end
        m = sgnv(a) * sgnv(e) * minv(absv(a), absv(e));
        return satv(b + m);
    endfunction

    function automatic int lane_get(logic [P*Q-1:0] v, int i);
        logic signed [Q-1:0] x;
        x = v[i*Q +: Q];
        return int'(x);
    endfunction

    function automatic logic [P*Q-1:0] rnd_vec();
        logic [P*Q-1:0] v;
        for (int i = 0; i < P; i++) v[i*Q +: Q] = Q'($urandom);
        return v;
    endfunction

    function automatic logic [P*Q-1:0] build(int v4[4], int fill);
        logic [P*Q-1:0] v;
        for (int i = 0; i < P; i++) v[i*Q +: Q] = Q'((i < 4) ? v4[i] : fill);
        return v;
    endfunction

    // Reference: a layer-L beat holds min(2^(L-1), P) alpha pairs; beats on
    // layers outside 1..log2(N) only raise the error pulse.
    function automatic exp_t model(stim_t s, bit discard);
        exp_t x;
        int   lanes;
        x = '{wen: 1'b0, err: 1'b0, lw: '0, cn: '0, a: '0};
        if (!s.valid || discard) return x;
        if (s.layer < 1 || s.layer > $clog2(N)) begin
            x.err = 1'b1;
            return x;
        end
        x.wen = 1'b1;
        x.lw  = s.layer - 5'd1;
        x.cn  = s.cnt;
        lanes = minv(2**(int'(s.layer) - 1), P);
        for (int i = 0; i < lanes; i++)
            x.a[i*Q +: Q] = Q'(lane_ref(s.op, lane_get(s.a, i), lane_get(s.b, i), lane_get(s.e, i)));
        return x;
    endfunction

    task automatic check_out(input exp_t x, input string tag);
        checks++;
        if (bus.w_en !== x.wen) begin
            errors++;
            $display("FAIL %s w_en got %0b want %0b", tag, bus.w_en, x.wen);
        end
        checks++;
        if (bus.err_layer !== x.err) begin
            errors++;
            $display("FAIL %s err_layer got %0b want %0b", tag, bus.err_layer, x.err);
        end
        checks++;
        if (bus.layer_w !== x.lw) begin
            errors++;
            $display("FAIL %s layer_w got %0d want %0d", tag, bus.layer_w, x.lw);
        end
        checks++;
        if (bus.cnta !== x.cn) begin
            errors++;
            $display("FAIL %s cnta got %0d want %0d", tag, bus.cnta, x.cn);
        end
        checks++;
        if (bus.a_out !== x.a) begin
            errors++;
            for (int i = 0; i < P; i++) begin
                if (bus.a_out[i*Q +: Q] !== x.a[i*Q +: Q]) begin
                    $display("FAIL %s a_out lane %0d got %0d want %0d", tag, i,
                             lane_get(bus.a_out, i), lane_get(x.a, i));
                    break;
                end
            end
        end
    endtask

    task automatic drive(input stim_t s);
        rst          = s.rst;
        bus.in_valid = s.valid;
        bus.op       = s.op;
        bus.layer_in = s.layer;
        bus.cnt_in   = s.cnt;
        bus.a_left   = s.a;
        bus.a_right  = s.b;
        bus.beta     = s.e;
    endtask

    function automatic stim_t mk(bit r, bit v, bit op, int layer, int cnt);
        stim_t s;
        s.rst = r; s.valid = v; s.op = op;
        s.layer = 5'(layer); s.cnt = 5'(cnt);
        s.a = rnd_vec(); s.b = rnd_vec(); s.e = rnd_vec();
        return s;
    endfunction

    // A beat driven at negedge t is captured at the next posedge and shows on
    // the outputs at negedge t+3; rst seen at any of those three edges kills it.
    task automatic step(input stim_t s);
        @(negedge clk);
        if (cyc >= 3)
            check_out(model(hist[cyc-3], hist[cyc-3].rst || hist[cyc-2].rst || hist[cyc-1].rst), phase);
        drive(s);
        if (cyc < HMAX) begin
            hist[cyc] = s;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        stim_t s;
        exp_t  x;
        string tag;
        tag = $sformatf("vec%0d", idx);
        s.rst = 1'b0; s.valid = 1'b1; s.op = v.op;
        s.layer = 5'(v.layer); s.cnt = 5'(v.cnt);
        s.a = build(v.a, v.fill); s.b = build(v.b, v.fill); s.e = build(v.e, v.fill);
        x.wen = v.wen; x.err = v.err; x.lw = 5'(v.lw);
        x.cn  = v.wen ? 5'(v.cnt) : 5'd0;
        x.a   = build(v.ex, v.ex_hi);
        @(negedge clk);
        drive(s);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_out(x, tag);
        @(negedge clk);
        check_out('{wen: 1'b0, err: 1'b0, lw: '0, cn: '0, a: '0}, {tag, "_after"});
    endtask

    vec_t tbl [8];

    initial begin
        bus.in_valid = 1'b0; bus.op = 1'b0; bus.layer_in = '0; bus.cnt_in = '0;
        bus.a_left = '0; bus.a_right = '0; bus.beta = '0;

        tbl[0] = '{op: 1'b0, layer: 9, cnt: 0, a: '{10, -31, 0, 0}, b: '{-4, 20, 0, 0},
                   e: '{1, 20, 0, 0}, fill: 0, ex: '{-3, -31, 0, 0}, ex_hi: 0,
                   wen: 1'b1, err: 1'b0, lw: 8};
        tbl[1] = '{op: 1'b1, layer: 9, cnt: 0, a: '{-5, 12, -32, 0}, b: '{30, 28, -10, 0},
                   e: '{7, 9, -31, 0}, fill: 0, ex: '{25, 31, 21, 0}, ex_hi: 0,
                   wen: 1'b1, err: 1'b0, lw: 8};
        tbl[2] = '{op: 1'b1, layer: 3, cnt: 0, a: '{5, 5, 5, 5}, b: '{5, 5, 5, 5},
                   e: '{5, 5, 5, 5}, fill: 5, ex: '{10, 10, 10, 10}, ex_hi: 0,
                   wen: 1'b1, err: 1'b0, lw: 2};
        tbl[3] = '{op: 1'b0, layer: 11, cnt: 4, a: '{3, 3, 3, 3}, b: '{3, 3, 3, 3},
                   e: '{3, 3, 3, 3}, fill: 3, ex: '{0, 0, 0, 0}, ex_hi: 0,
                   wen: 1'b0, err: 1'b1, lw: 0};
        tbl[4] = '{op: 1'b1, layer: 0, cnt: 2, a: '{9, -9, 9, 9}, b: '{1, 1, 1, 1},
                   e: '{2, 2, 2, 2}, fill: 4, ex: '{0, 0, 0, 0}, ex_hi: 0,
                   wen: 1'b0, err: 1'b1, lw: 0};
        tbl[5] = '{op: 1'b0, layer: 1, cnt: 3, a: '{-8, 7, 7, 7}, b: '{3, 3, 3, 3},
                   e: '{-20, 1, 1, 1}, fill: 7, ex: '{8, 0, 0, 0}, ex_hi: 0,
                   wen: 1'b1, err: 1'b0, lw: 0};
        tbl[6] = '{op: 1'b1, layer: 10, cnt: 1, a: '{31, 0, -1, 3}, b: '{-32, -32, 0, -2},
                   e: '{-31, 5, 0, -7}, fill: 1, ex: '{-31, -31, 0, -5}, ex_hi: 2,
                   wen: 1'b1, err: 1'b0, lw: 9};
        tbl[7] = '{op: 1'b0, layer: 9, cnt: 0, a: '{20, -32, 0, 0}, b: '{-32, 0, 0, 0},
                   e: '{-20, 0, 0, 0}, fill: -3, ex: '{-20, 0, 0, 0}, ex_hi: 3,
                   wen: 1'b1, err: 1'b0, lw: 8};

        // Reset held with live random beats, then released into idle cycles.
        for (int i = 0; i < 3; i++) step(mk(1'b1, 1'b1, i[0], 9, 0));
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b0, 9, 0));

        phase = "stream";
        step(mk(1'b0, 1'b1, 1'b0, 10, 0));
        step(mk(1'b0, 1'b1, 1'b1, 10, 1));
        step(mk(1'b0, 1'b1, 1'b0, 8, 0));
        step(mk(1'b0, 1'b1, 1'b1, 9, 0));
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b0, 0, 0));

        phase = "illegal";
        step(mk(1'b0, 1'b1, 1'b0, 11, 0));
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b0, 0, 0));

        phase = "midrst";
        step(mk(1'b0, 1'b1, 1'b0, 9, 0));
        step(mk(1'b0, 1'b1, 1'b1, 10, 1));
        step(mk(1'b1, 1'b0, 1'b0, 9, 0));
        step(mk(1'b0, 1'b1, 1'b1, 7, 0));
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b0, 0, 0));

        phase = "random";
        for (int i = 0; i < 250; i++) begin
            int lay;
            lay = ($urandom_range(0, 9) == 0)
                ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(11, 31)))
                : int'($urandom_range(1, 10));
            step(mk($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom), lay, int'($urandom_range(0, 31))));
        end
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b0, 0, 0));
        step(mk(1'b0, 1'b0, 1'b0, 0, 0));

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_fg_pe_array.md
Name: scan_fg_pe_array

Overview:
- P-lane pipelined SCAN processing-element array that sits directly downstream of the alpha LLR store.
- Consumes one read beat of left/right alpha pairs plus one beta vector per cycle.
- Computes the SCAN left (f) or right (g) min-sum update per lane.
- Returns the results with write-side control (layer, count, enable) so they can be written straight back into the alpha store at layer-1.

Parameters:
- Q, 6, LLR width in bits, two's complement.
- P, 256, number of lanes (alpha pairs per beat).
- N, 1024, code length; top layer index = log2(N) = 10.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat qualifier for a_left/a_right/beta/op/layer_in/cnt_in
- op  in  1  0 = left (f) update, 1 = right (g) update
- layer_in  in  5  source layer of the alpha pair (1..10)
- cnt_in  in  5  beat index within the layer
- a_left  in  P*Q  alpha of upper half, lane i at bits [i*Q+Q-1 : i*Q]
- a_right  in  P*Q  alpha of lower half, same packing
- beta  in  P*Q  partner beta (right-child beta for op=0, left-child beta for op=1), same packing
- a_out  out  P*Q  updated alpha, same packing
- w_en  out  1  write strobe toward alpha store
- layer_w  out  5  destination layer = layer_in-1
- cnta  out  5  destination beat index = cnt_in
- err_layer  out  1  one-cycle pulse: beat carried an illegal layer

Behaviour:
- Reset: all pipeline registers cleared. a_out=0, w_en=0, layer_w=0, cnta=0, err_layer=0.
- Pipeline is fully pipelined: 2 stages, one beat accepted per cycle, no backpressure, no stall input.
- Latency: in_valid at edge n → w_en/a_out/layer_w/cnta (or err_layer) valid for exactly one cycle after edge n+2.
- Back-to-back beats produce back-to-back w_en. A cycle with in_valid=0 produces w_en=0 two cycles later. a_out is don't-care when w_en=0 and is driven 0 in that case.
- Saturation sat(x): clip to [-(2^(Q-1)-1), +(2^(Q-1)-1)]. Q=6 gives [-31, +31].
- Input value -2^(Q-1) is treated as -(2^(Q-1)-1) before any use.
- sgn(x): +1 if x>=0, -1 if x<0.
- Intermediate sums are computed at Q+1 bits, then saturated.
- Lane update, with A=a_left[i], B=a_right[i], E=beta[i]:
  - op=0: T=sat(B+E); out = sgn(A)·sgn(T)·min(|A|,|T|).
  - op=1: M = sgn(A)·sgn(E)·min(|A|,|E|); out = sat(B+M).
- Stage 1 registers T (or E), both signs, min magnitude, B and tags. Stage 2 applies the sign, performs the g addition and saturation, and masks lanes.
- Active lanes:
  - layer_in 9 or 10: all P lanes.
  - layer_in L in 1..8: lanes 0..2^(L-1)-1 only.
  - Inactive lanes output exactly 0.
- Layer 10 needs 2 beats (cnt_in 0,1) to produce 512 outputs. Layers ≤9 use 1 beat (cnt_in passed through unchanged, not checked).
- Illegal layer: layer_in=0 or >10 with in_valid=1 → w_en stays 0, err_layer pulses at the same latency, a_out=0, layer_w/cnta=0.
- op and tags are captured per beat. Changing op every cycle is legal; each beat uses its own op.
- rst asserted mid-stream: all in-flight beats are discarded and no w_en is produced for them. First beat accepted on the cycle after rst deasserts appears 2 cycles later.
- rst has priority over in_valid in the same cycle.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 and random data → w_en, err_layer, a_out, layer_w, cnta all 0 throughout and 2 cycles after release.
- f update, Q=6, layer 9, op=0, lane0 A=10, B=-4, E=1 (T=-3); lane1 A=-31, B=20, E=20 (T=sat 31) → one cycle after edge n+2: a_out lane0=-3, lane1=-31, w_en=1, layer_w=8.
- g update, layer 9, op=1, lane0 A=-5, B=30, E=7 (M=-5) → 25; lane1 A=12, B=28, E=9 (M=9) → sat 31; lane2 A=-32 (treated -31), B=-10, E=-31 → M=31, out 21.
- Narrow layer masking: layer_in=3, all lanes A=B=E=5, op=1 → lanes 0..3 = 10, lanes 4..255 = 0, layer_w=2.
- Streaming: 4 consecutive beats (layer 10 cnt 0, layer 10 cnt 1, layer 8, layer 9), op alternating 0/1 → 4 consecutive w_en pulses with cnta 0,1,0,0 and layer_w 9,9,7,8, each matching the reference model.
- Illegal layer and mid-stream reset: beat with layer_in=11 → err_layer=1, w_en=0. Then 2 valid beats followed by rst asserted on the next cycle → neither beat produces w_en.
